// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // REQ: request issued, WAIT: live response pending,
  // DROP: pending response belongs to a flushed path, HALT: misaligned target seen.
  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: DEPTH-entry {instr, pc} FIFO
// with synchronous flush. DEPTH must be 2 or 4.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a
// registered instruction buffer, with redirect/flush handling.
// Optional feature macro FETCH_MISALIGN_EN: a misaligned redirect target
// halts fetch and raises a sticky misalign_err; otherwise the low target
// bits are cleared.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcplus4,
  input  logic            decode_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic            run_q;
  logic            bad_target;
  logic            push, pop, flush;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    head, push_entry;

`ifdef FETCH_MISALIGN_EN
  logic misalign_q;
  assign bad_target   = |redirect_pc[1:0];
  assign misalign_err = misalign_q;

  // Sticky error: set when the FSM is about to halt, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if (state_d == ST_HALT) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign bad_target   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign imem_addr     = pc_q;
  assign push_entry    = '{instr: imem_rdata, pc: tag_q};
  assign instr_valid   = !fifo_empty;
  assign instr         = instr_valid ? head.instr : '0;
  assign instr_pc      = instr_valid ? head.pc : '0;
  assign instr_pcplus4 = instr_valid ? head.pc + XLEN'(4) : '0;
  assign pop           = instr_valid && decode_ready && !redirect_valid;

  // State, fetch PC, tag of the outstanding request and post-reset start flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state, fetch PC and buffer control; redirect outranks push and pop.
  // A request is only raised while the buffer can absorb its response, so
  // a push can never meet a full buffer.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tag_d    = tag_q;
    push     = 1'b0;
    flush    = 1'b0;
    imem_req = run_q && (state_q == ST_REQ) && !fifo_full;

    if ((state_q != ST_HALT) && redirect_valid) begin
      flush = 1'b1;
      if (bad_target) begin
        state_d = ST_HALT;
      end else begin
        pc_d = redirect_pc & ALIGN_MASK;
        unique case (state_q)
          ST_REQ:          if (imem_req && imem_gnt) state_d = ST_DROP;
          ST_WAIT, ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
          default:         state_d = state_q;
        endcase
      end
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (imem_req && imem_gnt) begin
            tag_d   = pc_q;
            pc_d    = pc_q + XLEN'(4);
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) state_d = ST_REQ;
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic, checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
`ifdef FETCH_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pcplus4  (instr_pcplus4),
    .decode_ready   (decode_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level model: expected fetch address stream and the ordered
  // list of instructions decode should see.
  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_pc;
  logic [31:0] tag;
  bit          started, halted, outst, discard, err_exp;

  // Memory responder
  bit          mem_pend;
  int unsigned mem_cnt;
  logic [31:0] data_q[$];

  // Observations at decode
  logic [31:0] seen_pc[$];
  logic [31:0] seen_data[$];
  int          grants;

  function automatic bit exp_req();
    return started && !halted && !outst && (q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] first_seen();
    return (seen_pc.size() != 0) ? seen_pc[0] : 32'hxxxx_xxxx;
  endfunction

  task automatic do_reset(input bit stale);
    reset          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    decode_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_instr_pcplus4", instr_pcplus4, 0);
    check("rst_misalign_err", misalign_err, 0);
    q.delete();
    data_q.delete();
    seen_pc.delete();
    seen_data.delete();
    exp_pc   = 32'h0000_0000;
    tag      = '0;
    started  = 0;
    halted   = 0;
    outst    = 0;
    discard  = 0;
    err_exp  = 0;
    mem_pend = stale;
    mem_cnt  = 1;
    reset    = 1'b1;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick(input bit g, input bit rdy, input bit rd,
                      input logic [31:0] rpc, input int unsigned lat);
    bit granted, rv;
    check("instr_valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("instr", instr, q[0].data);
      check("instr_pc", instr_pc, q[0].pc);
      check("instr_pcplus4", instr_pcplus4, q[0].pc + 32'd4);
    end
    check("imem_req", imem_req, exp_req());
    if (exp_req()) check("imem_addr", imem_addr, exp_pc);
    check("misalign_err", misalign_err, err_exp);

    imem_gnt       = g;
    decode_ready   = rdy;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_rvalid = 1'b1;
        mem_pend    = 0;
        if (data_q.size() != 0) imem_rdata = data_q.pop_front();
      end else begin
        mem_cnt--;
      end
    end
    #1;
    if (imem_req && g) grants++;
    if (instr_valid && rdy && !rd) begin
      seen_pc.push_back(instr_pc);
      seen_data.push_back(instr);
    end

    granted = exp_req() && g;
    rv      = imem_rvalid && outst;
    if (!halted) begin
      if (rd) begin
        q.delete();
        if (MIS && rpc[1:0] != 2'b00) begin
          halted  = 1;
          err_exp = 1;
        end else begin
          exp_pc = rpc & 32'hFFFF_FFFC;
        end
        if (granted) begin
          outst   = 1;
          discard = 1;
        end else if (rv) begin
          outst   = 0;
          discard = 0;
        end else if (outst) begin
          discard = 1;
        end
      end else begin
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (rv) begin
          if (!discard) q.push_back('{imem_rdata, tag});
          outst   = 0;
          discard = 0;
        end
        if (granted) begin
          tag     = exp_pc;
          exp_pc  = exp_pc + 32'd4;
          outst   = 1;
          discard = 0;
        end
      end
    end
    if (imem_req && g) begin
      mem_pend = 1;
      mem_cnt  = lat;
    end
    started = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rpc;
    bit          rd;

    // Streaming fetch, 1-cycle memory latency
    do_reset(0);
    data_q.push_back(32'h0050_0093);
    repeat (12) tick(1, 1, 0, 0, 1);
    check("stream_pc0", first_seen(), 32'h0);
    check("stream_pc1", seen_pc.size() > 1 ? seen_pc[1] : 32'hx, 32'h4);
    check("stream_pc2", seen_pc.size() > 2 ? seen_pc[2] : 32'hx, 32'h8);
    check("stream_data0", seen_data.size() != 0 ? seen_data[0] : 32'hx, 32'h0050_0093);

    // Backpressure: buffer fills, one pop frees exactly one request
    do_reset(0);
    repeat (10) tick(1, 0, 0, 0, 1);
    check("full_req", imem_req, 0);
    check("full_valid", instr_valid, 1);
    grants = 0;
    tick(1, 1, 0, 0, 1);
    repeat (8) tick(1, 0, 0, 0, 1);
    check("refill_grants", grants, 1);

    // Grant withheld: address holds, then advances once
    do_reset(0);
    tick(0, 1, 0, 0, 1);
    repeat (3) tick(0, 1, 0, 0, 1);
    check("hold_req", imem_req, 1);
    check("hold_addr", imem_addr, 32'h0);
    tick(1, 1, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    check("adv_addr", imem_addr, 32'h4);

    // Redirect in WAIT, stale response two cycles later
    do_reset(0);
    tick(0, 1, 0, 0, 3);
    tick(1, 1, 0, 0, 3);
    tick(0, 1, 1, 32'h100, 3);
    tick(0, 1, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    repeat (6) tick(1, 1, 0, 0, 1);
    check("redir_first_pc", first_seen(), 32'h100);

    // Redirect coinciding with the response
    do_reset(0);
    tick(0, 1, 0, 0, 2);
    tick(1, 1, 0, 0, 2);
    tick(0, 1, 0, 0, 2);
    tick(0, 1, 1, 32'h200, 2);
    check("redir_rv_req", imem_req, 1);
    check("redir_rv_addr", imem_addr, 32'h200);
    check("redir_rv_valid", instr_valid, 0);

    // Misaligned redirect target
    do_reset(0);
    repeat (4) tick(1, 1, 0, 0, 1);
    tick(1, 1, 1, 32'h102, 1);
`ifdef FETCH_MISALIGN_EN
    check("mis_err", misalign_err, 1);
    check("mis_req", imem_req, 0);
    repeat (4) tick(1, 1, 0, 0, 1);
    check("mis_req_held", imem_req, 0);
    check("mis_valid", instr_valid, 0);
`else
    check("mis_req", imem_req, 1);
    check("mis_addr", imem_addr, 32'h100);
    repeat (4) tick(1, 1, 0, 0, 1);
`endif

    // PC wrap at the top of the address space
    do_reset(0);
    tick(0, 1, 1, 32'hFFFF_FFFC, 1);
    tick(1, 1, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'h0);
    repeat (2) tick(1, 1, 0, 0, 1);
    check("wrap_pc", first_seen(), 32'hFFFF_FFFC);

    // Reset mid-WAIT with a stale response in the first post-reset cycle
    do_reset(0);
    tick(0, 1, 0, 0, 3);
    tick(1, 1, 0, 0, 3);
    do_reset(1);
    repeat (6) tick(1, 1, 0, 0, 1);
    check("rst_stale_pc", first_seen(), 32'h0);

    // Randomized traffic
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 599) do_reset(1'($urandom_range(0, 1)));
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      if ($urandom_range(0, 29) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      tick(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6, rd, rpc,
           $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, the instruction buffer entry count; legal values are 2 and 4.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, word-aligned.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  read data valid, one or more cycles after the grant.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  the buffer head holds an instruction for decode.
REQ-011 instr  output  32  instruction to decode; bits [31:7] feed the immediate extender.
REQ-012 instr_pc  output  32  PC of instr.
REQ-013 instr_pcplus4  output  32  instr_pc + 4.
REQ-014 decode_ready  input  1  decode consumes the head when instr_valid and decode_ready are both 1.
REQ-015 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-016 redirect_pc  input  32  new fetch target.
REQ-017 misalign_err  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-018 FSM states: REQ (imem_req=1), WAIT (one request outstanding), DROP (an outstanding response is to be discarded), HALT.
REQ-019 At most one outstanding request at any time.
REQ-020 REQ is entered only when buffer count + outstanding < DEPTH; otherwise imem_req=0.
REQ-021 REQ with imem_gnt=1: latch the tag PC=imem_addr, set fetch PC to fetch PC+4 (32-bit wrap; 32'hFFFF_FFFC wraps to 0), go to WAIT.
REQ-022 WAIT with imem_rvalid=1: push {imem_rdata, tag PC} into the buffer and go to REQ in the same edge; there is no bubble between back-to-back fetches.
REQ-023 imem_addr and imem_req are held stable while imem_req=1 and imem_gnt=0.
REQ-024 The buffer is FIFO: push on rvalid, pop on instr_valid&&decode_ready, and a simultaneous push and pop leaves the count unchanged.
REQ-025 Latency: with an empty buffer, instr_valid rises the cycle after imem_rvalid; the buffer is registered, with no rdata-to-instr combinational path.
REQ-026 redirect_valid=1 clears the buffer (instr_valid=0 the next cycle), sets fetch PC=redirect_pc, and discards any pop that cycle.
REQ-027 Redirect in WAIT without rvalid goes to DROP; the next rvalid is discarded, then the FSM goes to REQ.
REQ-028 Redirect in WAIT with rvalid in the same cycle discards that data and goes to REQ.
REQ-029 Redirect in REQ with imem_gnt=1 treats the granted request as outstanding and goes to DROP.
REQ-030 Redirect in REQ with imem_gnt=0 drops the request and reissues at redirect_pc the next cycle.
REQ-031 Redirect in DROP keeps DROP and updates fetch PC; the latest redirect wins.
REQ-032 A redirect has priority over push and pop in the same cycle.

Reset
REQ-033 While reset=0: state=REQ, fetch PC=RESET_PC, buffer empty, instr_valid=0, imem_req=0, instr/instr_pc/instr_pcplus4=0, misalign_err=0.
REQ-034 imem_req first rises on the first edge after reset deasserts.
REQ-035 Reset mid-WAIT abandons the outstanding response, and any rvalid in the first post-reset cycle is ignored.

Configuration
REQ-036 With FETCH_MISALIGN_EN defined, a redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until reset), enters HALT (imem_req=0, instr_valid=0), and ignores the target.
REQ-037 Without FETCH_MISALIGN_EN, redirect_pc[1:0] are forced to 0, misalign_err is tied 0, and HALT is unreachable.

Structure
REQ-038 Package fetch_pkg holds the FSM state enum, the RESET_PC default, and the XLEN=32 constant.
REQ-039 Sub-module fetch_fifo holds the DEPTH-entry {instr, pc} buffer with count, push, pop and flush.

Verification
REQ-040 Reset release, gnt=1, rvalid one cycle after gnt, ready=1: instr_pc sequence 0,4,8; a data word of 32'h00500093 appears with instr_pc=0 and instr_pcplus4=4.
REQ-041 decode_ready=0 with DEPTH=2: after 2 instructions are buffered, imem_req=0; one pop then issues exactly one new request.
REQ-042 Redirect to 32'h100 while in WAIT, stale rvalid 2 cycles later: stale data is never visible, and the next instr_pc=32'h100.
REQ-043 gnt held 0 for 3 cycles: imem_addr stays constant, then fetch PC advances once on the grant.
REQ-044 Redirect and rvalid in the same cycle: the data is discarded and the next imem_addr=redirect_pc.
REQ-045 FETCH_MISALIGN_EN with redirect to 32'h102: misalign_err=1 and imem_req=0 until reset. Without the macro, fetch resumes at 32'h100.
